// File: rtl/imem_fetch_queue.sv
// Registered, runtime-loadable instruction memory with a back-pressurable in-order response queue.
// Build macro IMEM_BOUNDS_CHECK_EN enables out-of-range fault detection (fault code 2'b10).

module imem_fetch_queue #(
    parameter int unsigned INS_ADDRESS = 32,
    parameter int unsigned INS_W       = 32,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned FIFO_DEPTH  = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [INS_ADDRESS-1:0]     req_addr,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [INS_W-1:0]           rsp_instr,
    output logic [INS_ADDRESS-1:0]     rsp_addr,
    output logic [1:0]                 rsp_fault,
    input  logic                       flush,
    input  logic                       prog_we,
    input  logic [$clog2(DEPTH)-1:0]   prog_addr,
    input  logic [INS_W-1:0]           prog_data
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic [INS_W-1:0]       mem [DEPTH];
    logic [INS_W-1:0]       rd_data_q;

    logic                   inf_valid_q, inf_valid_d;
    logic [INS_ADDRESS-1:0] inf_addr_q,  inf_addr_d;
    logic [1:0]             inf_fault_q, inf_fault_d;

    logic [INS_W-1:0]       q_instr [FIFO_DEPTH];
    logic [INS_ADDRESS-1:0] q_addr  [FIFO_DEPTH];
    logic [1:0]             q_fault [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q,  count_d;

    logic                   accept_c;
    logic                   push_c;
    logic                   pop_c;
    logic                   misaligned_c;
    logic                   out_of_range_c;
    logic [1:0]             req_fault_c;
    logic [AW-1:0]          req_idx_c;
    logic [CW-1:0]          occ_c;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Request decode and fault classification (misaligned wins).
    assign req_idx_c    = req_addr[AW+1:2];
    assign misaligned_c = |req_addr[1:0];
`ifdef IMEM_BOUNDS_CHECK_EN
    assign out_of_range_c = (req_addr >> 2) >= INS_ADDRESS'(DEPTH);
`else
    assign out_of_range_c = 1'b0;
`endif
    assign req_fault_c = misaligned_c   ? 2'b01 :
                         out_of_range_c ? 2'b10 : 2'b00;

    // occ counts the in-flight read plus queued entries; it never exceeds FIFO_DEPTH.
    assign occ_c     = count_q + CW'(inf_valid_q);
    assign req_ready = !reset && !flush && !prog_we && (occ_c < CW'(FIFO_DEPTH));
    assign accept_c  = req_valid && req_ready;
    assign push_c    = inf_valid_q && !flush && !reset;
    assign pop_c     = rsp_valid && rsp_ready;

    assign rsp_valid = !reset && (count_q != '0);
    assign rsp_instr = rsp_valid ? q_instr[rd_ptr_q] : '0;
    assign rsp_addr  = rsp_valid ? q_addr[rd_ptr_q]  : '0;
    assign rsp_fault = rsp_valid ? q_fault[rd_ptr_q] : 2'b00;

    always_comb begin
        inf_valid_d = accept_c;
        inf_addr_d  = inf_addr_q;
        inf_fault_d = inf_fault_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (accept_c) begin
            inf_addr_d  = req_addr;
            inf_fault_d = req_fault_c;
        end
        if (flush) begin
            inf_valid_d = 1'b0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
        end else begin
            if (push_c) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_c)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CW'(push_c) - CW'(pop_c);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inf_valid_q <= 1'b0;
            inf_addr_q  <= '0;
            inf_fault_q <= 2'b00;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            inf_valid_q <= inf_valid_d;
            inf_addr_q  <= inf_addr_d;
            inf_fault_q <= inf_fault_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Faulting fetches carry a zero instruction word into the queue.
    always_ff @(posedge clk) begin
        if (push_c) begin
            q_instr[wr_ptr_q] <= (inf_fault_q != 2'b00) ? '0 : rd_data_q;
            q_addr[wr_ptr_q]  <= inf_addr_q;
            q_fault[wr_ptr_q] <= inf_fault_q;
        end
    end

    // Memory is not reset; a read issued alongside a program write sees the old word.
    always_ff @(posedge clk) begin
        if (prog_we && !reset) mem[prog_addr] <= prog_data;
        if (accept_c)          rd_data_q      <= mem[req_idx_c];
    end

endmodule

// File: tb/tb_imem_fetch_queue.sv
// Testbench for imem_fetch_queue: directed test-plan steps plus a randomized phase,
// checked every cycle against a queue-based reference model.

module tb_imem_fetch_queue;

    localparam int unsigned AWID  = 32;
    localparam int unsigned IW    = 32;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned FD    = 3;
    localparam int unsigned IDXW  = 6;
`ifdef IMEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            req_valid;
    logic            req_ready;
    logic [AWID-1:0] req_addr;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IW-1:0]   rsp_instr;
    logic [AWID-1:0] rsp_addr;
    logic [1:0]      rsp_fault;
    logic            flush;
    logic            prog_we;
    logic [IDXW-1:0] prog_addr;
    logic [IW-1:0]   prog_data;

    always #5 clk = ~clk;

    imem_fetch_queue #(
        .INS_ADDRESS(AWID), .INS_W(IW), .DEPTH(DEPTH), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
        .rsp_addr(rsp_addr), .rsp_fault(rsp_fault), .flush(flush),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
    );

    typedef struct {
        int unsigned k;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [1:0]  fault;
    } rsp_t;

    rsp_t        pend[$];
    logic [31:0] mmem [DEPTH];
    int unsigned n = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    bit          acc = 1'b0;
    bit          zero_next = 1'b0;

    function automatic rsp_t model_fetch(input logic [31:0] a);
        rsp_t r;
        r.addr  = a;
        r.k     = 0;
        if (a % 4 != 0)                  r.fault = 2'b01;
        else if (BOUNDS && a / 4 >= DEPTH) r.fault = 2'b10;
        else                             r.fault = 2'b00;
        r.instr = (r.fault != 2'b00) ? 32'h0 : mmem[(a / 4) % DEPTH];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs mid-cycle, then advance the model at the rising edge.
    task automatic tick();
        bit   er, ev;
        rsp_t h;
        @(negedge clk);
        er = !reset && !flush && !prog_we && (pend.size() < FD);
        ev = !reset && pend.size() > 0 && (pend[0].k + 2 <= n);
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("rsp_valid", 32'(rsp_valid), 32'(ev));
        if (ev) begin
            chk("rsp_instr", rsp_instr, pend[0].instr);
            chk("rsp_addr",  rsp_addr,  pend[0].addr);
            chk("rsp_fault", 32'(rsp_fault), 32'(pend[0].fault));
        end else if (reset || zero_next) begin
            chk("rst_instr", rsp_instr, 32'h0);
            chk("rst_addr",  rsp_addr,  32'h0);
            chk("rst_fault", 32'(rsp_fault), 32'h0);
        end
        zero_next = reset;
        @(posedge clk);
        acc = req_valid && er;
        if (reset || flush) begin
            pend.delete();
        end else begin
            if (ev && rsp_ready) void'(pend.pop_front());
            if (acc) begin
                h   = model_fetch(req_addr);
                h.k = n;
                pend.push_back(h);
            end
        end
        if (prog_we && !reset) mmem[prog_addr] = prog_data;
        n++;
        #1;
    endtask

    task automatic issue(input logic [31:0] a, output int cyc);
        req_valid = 1'b1;
        req_addr  = a;
        cyc = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            cyc++;
            if (acc) break;
        end
        chk("accept_timeout", 32'(acc), 32'h1);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        for (int i = 0; i < 32 && pend.size() > 0; i++) tick();
        chk("drain_timeout", 32'(pend.size() == 0), 32'h1);
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 7)       return 32'($urandom_range(0, DEPTH - 1) * 4);
        else if (r == 7) return 32'($urandom_range(0, 255) * 4 + $urandom_range(1, 3));
        else             return ($urandom | 32'h100) & 32'hFFFF_FFFC;
    endfunction

    initial begin
        int cyc;
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        flush = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        for (int i = 0; i < DEPTH; i++) mmem[i] = 32'h0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Program load: fixed words at 0/1, random elsewhere.
        for (int i = 0; i < DEPTH; i++) begin
            prog_we   = 1'b1;
            prog_addr = IDXW'(i);
            prog_data = (i == 0) ? 32'h0020_0093 : (i == 1) ? 32'h0010_0113 : $urandom;
            tick();
        end
        prog_we = 1'b0;

        // Back-to-back fetch of the first two words.
        rsp_ready = 1'b1;
        issue(32'h0, cyc);
        issue(32'h4, cyc);
        chk("b2b_wait", 32'(cyc), 32'h1);
        drain();

        // Streaming: one accept per cycle.
        rsp_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            issue(32'(64 + 4 * i), cyc);
            chk("stream_wait", 32'(cyc), 32'h1);
        end
        drain();

        // Backpressure: only FIFO_DEPTH requests fit.
        rsp_ready = 1'b0;
        issue(32'h0, cyc);
        issue(32'h4, cyc);
        issue(32'h8, cyc);
        req_valid = 1'b1;
        req_addr  = 32'hC;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_blocked", 32'(acc), 32'h0);
        end
        rsp_ready = 1'b1;
        issue(32'hC, cyc);
        drain();

        // Faults: misaligned, then beyond the array.
        issue(32'h6, cyc);
        issue(32'h100, cyc);
        drain();

        // Flush with two fetches outstanding.
        rsp_ready = 1'b0;
        issue(32'h10, cyc);
        issue(32'h14, cyc);
        flush = 1'b1; req_valid = 1'b1; req_addr = 32'h18;
        tick();
        chk("flush_no_accept", 32'(acc), 32'h0);
        flush = 1'b0; req_valid = 1'b0;
        tick();
        rsp_ready = 1'b1;
        issue(32'h8, cyc);
        drain();

        // Reset with two entries queued; memory must survive.
        rsp_ready = 1'b0;
        issue(32'h0, cyc);
        issue(32'h4, cyc);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        rsp_ready = 1'b1;
        issue(32'h0, cyc);
        drain();

        // Randomized traffic with flushes and program writes.
        for (int i = 0; i < 600; i++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_addr  = rand_addr();
            rsp_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            prog_we   = ($urandom_range(0, 15) == 0);
            prog_addr = IDXW'($urandom);
            prog_data = $urandom;
            tick();
        end
        flush = 1'b0; prog_we = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
